// File: rtl/ptmch_seq.sv
// Measurement-window sequencer: arms, gates counters, counts masked trigger edges.
// Define PTMCH_SEQ_SYNC_EN to add a 2-flop synchronizer on TRG_PLS.
module ptmch_seq #(
  parameter int P_TRG_NUM = 5,
  parameter int P_WIN_W   = 32,
  parameter int P_EVT_W   = 16
) (
  input  logic                 CLK100M,
  input  logic                 RESET_N,
  input  logic [P_TRG_NUM-1:0] TRG_PLS,
  input  logic                 CMD_START,
  input  logic                 CMD_STOP,
  input  logic                 CMD_CLR,
  input  logic                 IRQ_ACK,
  input  logic [1:0]           CFG_MODE,
  input  logic [P_TRG_NUM-1:0] CFG_TRG_MASK,
  input  logic [2:0]           CFG_ARM_SRC,
  input  logic [P_WIN_W-1:0]   CFG_WINDOW,
  input  logic [P_EVT_W-1:0]   CFG_EVT_LIMIT,
  output logic                 CNT_EN,
  output logic                 CNT_CLR,
  output logic [P_EVT_W-1:0]   EVT_CNT,
  output logic [P_WIN_W-1:0]   ELAPSED,
  output logic [1:0]           STATE,
  output logic                 DONE_IRQ,
  output logic [1:0]           DONE_CAUSE,
  output logic                 OVF
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;
  localparam int LP_PW = $clog2(P_TRG_NUM + 1);

  logic [P_TRG_NUM-1:0] r_s, r_p;
  logic [1:0]           r_state;
  logic                 r_cnt_en, r_cnt_clr, r_irq, r_ovf;
  logic [1:0]           r_cause;
  logic [P_EVT_W-1:0]   r_evt;
  logic [P_WIN_W-1:0]   r_el;

  logic [P_TRG_NUM-1:0] w_edge, w_cnt_edge;
  logic [7:0]           w_edge8;
  logic [LP_PW-1:0]     w_pop;
  logic [P_EVT_W:0]     w_evt_sum;
  logic [P_WIN_W:0]     w_el_sum;
  logic [P_EVT_W-1:0]   w_evt_inc, w_lim_eff;
  logic [P_WIN_W-1:0]   w_el_inc, w_win_eff;
  logic                 w_imm, w_arm_hit;
  logic [1:0]           w_nstate, w_ncause;
  logic [P_EVT_W-1:0]   w_nevt;
  logic [P_WIN_W-1:0]   w_nel;
  logic                 w_novf, w_nclr, w_set_irq, w_clr_irq;
  logic                 w_start, w_count, w_stop;

`ifdef PTMCH_SEQ_SYNC_EN
  logic [P_TRG_NUM-1:0] r_meta;
  always_ff @(posedge CLK100M or negedge RESET_N) begin
    if (!RESET_N) begin
      r_meta <= '0;
      r_s    <= '0;
    end else begin
      r_meta <= TRG_PLS;
      r_s    <= r_meta;
    end
  end
`else
  always_ff @(posedge CLK100M or negedge RESET_N) begin
    if (!RESET_N) r_s <= '0;
    else          r_s <= TRG_PLS;
  end
`endif

  always_ff @(posedge CLK100M or negedge RESET_N) begin
    if (!RESET_N) r_p <= '0;
    else          r_p <= r_s;
  end

  assign w_edge     = r_s & ~r_p;
  assign w_cnt_edge = w_edge & CFG_TRG_MASK;
  assign w_edge8    = 8'(w_edge);
  assign w_imm      = CFG_ARM_SRC >= 3'd5;
  assign w_arm_hit  = w_edge8[CFG_ARM_SRC];

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < P_TRG_NUM; i++)
      w_pop = w_pop + LP_PW'(w_cnt_edge[i]);
  end

  // Saturating increments; the carry-out marks overflow.
  assign w_evt_sum = {1'b0, r_evt} + (P_EVT_W+1)'(w_pop);
  assign w_el_sum  = {1'b0, r_el} + {{P_WIN_W{1'b0}}, 1'b1};
  assign w_evt_inc = w_evt_sum[P_EVT_W] ? '1 : w_evt_sum[P_EVT_W-1:0];
  assign w_el_inc  = w_el_sum[P_WIN_W] ? '1 : w_el_sum[P_WIN_W-1:0];
  assign w_win_eff = (CFG_WINDOW == '0) ? P_WIN_W'(1) : CFG_WINDOW;
  assign w_lim_eff = (CFG_EVT_LIMIT == '0) ? P_EVT_W'(1) : CFG_EVT_LIMIT;

  always_comb begin
    w_nstate  = r_state;
    w_ncause  = r_cause;
    w_nevt    = r_evt;
    w_nel     = r_el;
    w_novf    = r_ovf;
    w_nclr    = 1'b0;
    w_set_irq = 1'b0;
    w_clr_irq = 1'b0;
    w_start   = 1'b0;
    w_count   = 1'b0;
    w_stop    = 1'b0;
    if (CMD_CLR) begin
      w_nstate  = S_IDLE;
      w_ncause  = 2'd0;
      w_nevt    = '0;
      w_nel     = '0;
      w_novf    = 1'b0;
      w_nclr    = 1'b1;
      w_clr_irq = 1'b1;
    end else begin
      unique case (r_state)
        S_IDLE:  w_start = CMD_START;
        S_ARMED: begin
          if (CMD_STOP)       w_nstate = S_IDLE;
          else if (CMD_START) w_start  = 1'b1;
          else if (w_arm_hit) w_count  = 1'b1;
        end
        S_RUN: begin
          if (CMD_STOP) begin
            w_stop  = 1'b1;
            w_count = 1'b1;
          end else if (CMD_START) w_start = 1'b1;
          else                    w_count = 1'b1;
        end
        S_HOLD:  w_start = CMD_START;
      endcase
      if (w_start) begin
        w_nstate = w_imm ? S_RUN : S_ARMED;
        w_ncause = 2'd0;
        w_nevt   = '0;
        w_nel    = '0;
        w_novf   = 1'b0;
        w_nclr   = 1'b1;
      end
      if (w_count) begin
        w_nevt   = w_evt_inc;
        w_nel    = w_el_inc;
        w_novf   = r_ovf | w_evt_sum[P_EVT_W] | w_el_sum[P_WIN_W];
        w_nstate = S_RUN;
        if (w_stop) begin
          w_nstate  = S_HOLD;
          w_ncause  = 2'd1;
          w_set_irq = 1'b1;
        end else if (CFG_MODE == 2'd1 && w_el_inc >= w_win_eff) begin
          w_nstate  = S_HOLD;
          w_ncause  = 2'd2;
          w_set_irq = 1'b1;
        end else if (CFG_MODE == 2'd2 && w_evt_inc >= w_lim_eff) begin
          w_nstate  = S_HOLD;
          w_ncause  = 2'd3;
          w_set_irq = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK100M or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state   <= S_IDLE;
      r_cnt_en  <= 1'b0;
      r_cnt_clr <= 1'b0;
      r_cause   <= 2'd0;
      r_evt     <= '0;
      r_el      <= '0;
      r_ovf     <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      r_state   <= w_nstate;
      r_cnt_en  <= (w_nstate == S_RUN);
      r_cnt_clr <= w_nclr;
      r_cause   <= w_ncause;
      r_evt     <= w_nevt;
      r_el      <= w_nel;
      r_ovf     <= w_novf;
      if (w_clr_irq)      r_irq <= 1'b0;
      else if (w_set_irq) r_irq <= 1'b1;
      else if (IRQ_ACK)   r_irq <= 1'b0;
    end
  end

  assign CNT_EN     = r_cnt_en;
  assign CNT_CLR    = r_cnt_clr;
  assign EVT_CNT    = r_evt;
  assign ELAPSED    = r_el;
  assign STATE      = r_state;
  assign DONE_IRQ   = r_irq;
  assign DONE_CAUSE = r_cause;
  assign OVF        = r_ovf;

endmodule

// File: tb/tb_ptmch_seq.sv
// Directed bench for ptmch_seq: scenario table plus hand-written corner sequences.
// A second instance with a 4-bit event counter covers saturation.
module tb_ptmch_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  trg = '0;
  logic        c_start = 0, c_stop = 0, c_clr = 0, ack = 0;
  logic [1:0]  mode = '0;
  logic [4:0]  mask = '0;
  logic [2:0]  src = 3'd7;
  logic [31:0] win = '0;
  logic [15:0] lim = '0;

  logic        cnt_en, cnt_clr, irq, ovf;
  logic [15:0] evt;
  logic [31:0] el;
  logic [1:0]  st, cause;
  logic        d4_en, d4_clr, d4_irq, d4_ovf;
  logic [3:0]  d4_evt;
  logic [31:0] d4_el;
  logic [1:0]  d4_st, d4_cause;

  int total = 0;
  int bad = 0;
  int en_cycles = 0;

  ptmch_seq u_dut (
    .CLK100M(clk), .RESET_N(rst_n), .TRG_PLS(trg),
    .CMD_START(c_start), .CMD_STOP(c_stop), .CMD_CLR(c_clr),
    .IRQ_ACK(ack), .CFG_MODE(mode), .CFG_TRG_MASK(mask),
    .CFG_ARM_SRC(src), .CFG_WINDOW(win), .CFG_EVT_LIMIT(lim),
    .CNT_EN(cnt_en), .CNT_CLR(cnt_clr), .EVT_CNT(evt),
    .ELAPSED(el), .STATE(st), .DONE_IRQ(irq),
    .DONE_CAUSE(cause), .OVF(ovf)
  );

  ptmch_seq #(.P_EVT_W(4)) u_dut4 (
    .CLK100M(clk), .RESET_N(rst_n), .TRG_PLS(trg),
    .CMD_START(c_start), .CMD_STOP(c_stop), .CMD_CLR(c_clr),
    .IRQ_ACK(ack), .CFG_MODE(mode), .CFG_TRG_MASK(mask),
    .CFG_ARM_SRC(src), .CFG_WINDOW(win), .CFG_EVT_LIMIT(lim[3:0]),
    .CNT_EN(d4_en), .CNT_CLR(d4_clr), .EVT_CNT(d4_evt),
    .ELAPSED(d4_el), .STATE(d4_st), .DONE_IRQ(d4_irq),
    .DONE_CAUSE(d4_cause), .OVF(d4_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mode;
    logic [2:0]  src;
    logic [4:0]  mask;
    logic [31:0] win;
    logic [15:0] lim;
    logic [4:0]  pat0;
    logic [4:0]  pat;
    int          n;
    bit          stop;
    int          exp_evt;
    int          exp_cause;
    int          exp_el;
    int          exp_en;
  } row_t;

  row_t rows[8];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    en_cycles += int'(cnt_en);
  endtask

  task automatic pulse(input logic [4:0] p);
    trg = p;
    tick();
    tick();
    trg = '0;
    tick();
    tick();
  endtask

  task automatic do_clr();
    c_clr = 1;
    tick();
    c_clr = 0;
    tick();
  endtask

  task automatic do_start();
    c_start = 1;
    tick();
    c_start = 0;
  endtask

  initial begin
    rows[0] = '{2'd1, 3'd7, 5'h1F, 32'd100, 16'd0, 5'h04, 5'h04,
                10, 1'b0, 10, 2, 100, 100};
    rows[1] = '{2'd2, 3'd0, 5'h03, 32'd0, 16'd4, 5'h01, 5'h02,
                4, 1'b0, 4, 3, -1, -1};
    rows[2] = '{2'd0, 3'd5, 5'h1F, 32'd0, 16'd0, 5'h1F, 5'h1F,
                1, 1'b1, 5, 1, -1, -1};
    rows[3] = '{2'd3, 3'd6, 5'h05, 32'd3, 16'd1, 5'h07, 5'h07,
                3, 1'b1, 6, 1, -1, -1};
    rows[4] = '{2'd1, 3'd7, 5'h1F, 32'd0, 16'd0, 5'h00, 5'h00,
                0, 1'b0, 0, 2, 1, 1};
    rows[5] = '{2'd2, 3'd7, 5'h10, 32'd0, 16'd0, 5'h10, 5'h10,
                1, 1'b0, 1, 3, -1, -1};
    rows[6] = '{2'd1, 3'd3, 5'h08, 32'd5, 16'd0, 5'h08, 5'h08,
                1, 1'b0, 1, 2, 5, -1};
    rows[7] = '{2'd0, 3'd7, 5'h00, 32'd0, 16'd0, 5'h1F, 5'h1F,
                2, 1'b1, 0, 1, -1, -1};

    #2;
    chk("rst_state", {st, cnt_en, cnt_clr, irq, cause, ovf}, '0);
    chk("rst_cnt", {evt, el}, '0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    tick();

    for (int r = 0; r < 8; r++) begin
      mode = rows[r].mode;
      src  = rows[r].src;
      mask = rows[r].mask;
      win  = rows[r].win;
      lim  = rows[r].lim;
      do_clr();
      en_cycles = 0;
      do_start();
      chk($sformatf("r%0d_clr", r), cnt_clr, 1);
      chk($sformatf("r%0d_st0", r), st, (src >= 3'd5) ? 2 : 1);
      for (int p = 0; p < rows[r].n; p++) begin
        if (st == 2'd3) break;
        pulse(p == 0 ? rows[r].pat0 : rows[r].pat);
      end
      if (rows[r].stop) begin
        c_stop = 1;
        ack = 1;
        tick();
        c_stop = 0;
        ack = 0;
      end
      for (int k = 0; k < 400 && st != 2'd3; k++) tick();
      chk($sformatf("r%0d_hold", r), st, 3);
      chk($sformatf("r%0d_evt", r), evt, rows[r].exp_evt);
      chk($sformatf("r%0d_cause", r), cause, rows[r].exp_cause);
      chk($sformatf("r%0d_irq", r), irq, 1);
      chk($sformatf("r%0d_en", r), cnt_en, 0);
      if (rows[r].exp_el >= 0)
        chk($sformatf("r%0d_el", r), el, rows[r].exp_el);
      if (rows[r].exp_en >= 0)
        chk($sformatf("r%0d_encyc", r), en_cycles, rows[r].exp_en);
    end

    // edge-to-count latency
    mode = 2'd0; src = 3'd7; mask = 5'h1F;
    do_clr();
    do_start();
    trg = 5'h01;
    tick();
    chk("lat_early", evt, 0);
    tick();
`ifdef PTMCH_SEQ_SYNC_EN
    chk("lat_mid", evt, 0);
    tick();
`endif
    chk("lat_cnt", evt, 1);
    trg = '0;
    tick();

    // stop coincides with window end
    mode = 2'd1; win = 32'd10;
    do_clr();
    do_start();
    for (int k = 0; k < 50 && el != 32'd9; k++) tick();
    chk("win9_reach", el, 9);
    c_stop = 1;
    tick();
    c_stop = 0;
    chk("coin_cause", cause, 1);
    chk("coin_el", el, 10);
    chk("coin_st", st, 3);

    ack = 1;
    tick();
    ack = 0;
    chk("ack_clr", irq, 0);

    // stop while armed
    mode = 2'd0; src = 3'd2;
    do_start();
    chk("armed_st", st, 1);
    c_stop = 1;
    tick();
    c_stop = 0;
    chk("armed_stop_st", st, 0);
    chk("armed_stop_irq", irq, 0);

    // 4-bit counter saturation
    src = 3'd7; mask = 5'h1F;
    do_clr();
    do_start();
    for (int p = 0; p < 20; p++) pulse(5'h01);
    c_stop = 1;
    tick();
    c_stop = 0;
    chk("sat_evt4", d4_evt, 15);
    chk("sat_ovf4", d4_ovf, 1);
    chk("sat_evt16", evt, 20);
    chk("sat_ovf16", ovf, 0);
    do_start();
    chk("rst_clr4", d4_clr, 1);
    chk("rst_evt4", d4_evt, 0);
    chk("rst_ovf4", d4_ovf, 0);
    chk("rst_st4", d4_st, 2);
    chk("rst_irq_kept", irq, 1);

    // clear mid-run
    pulse(5'h03);
    c_clr = 1;
    tick();
    c_clr = 0;
    chk("clr_stat", {st, cnt_en, irq, cause, ovf}, '0);
    chk("clr_cnt", {evt, el}, '0);
    chk("clr_pulse", cnt_clr, 1);
    tick();
    chk("clr_pulse_end", cnt_clr, 0);

    // async reset mid-run
    do_start();
    pulse(5'h01);
    tick();
    chk("pre_rst_run", st, 2);
    #2 rst_n = 0;
    #1;
    chk("arst_stat", {st, cnt_en, cnt_clr, irq, cause, ovf}, '0);
    chk("arst_cnt", {evt, el}, '0);
    @(negedge clk);
    rst_n = 1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
